sim_seq_ctrl: RTL

Parametrised simulation sequencer, the next generation of the simulation controller. It releases CHANNELS independent reset domains on a staggered schedule and keeps a saturating cycle count. It issues periodic progress pulses and ends the run on an external request, a cycle timeout or an idle watchdog, latching a reason code. A drain period runs before the done level that the testbench wraps with $finish.

---
 rtl/sim_seq_pkg.sv | 23 ++
 rtl/sim_seq_sat_cnt.sv | 25 ++
 rtl/sim_seq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sim_seq_pkg.sv
// Shared types for the simulation sequencer: FSM state and finish-reason codes,
// plus the per-channel reset release threshold helper.
package sim_seq_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sim_seq_state_t;

    typedef enum logic [1:0] {
        RSN_NONE    = 2'd0,
        RSN_REQUEST = 2'd1,
        RSN_TIMEOUT = 2'd2,
        RSN_IDLE    = 2'd3
    } sim_seq_reason_t;

    function automatic int rst_threshold(int base, int stagger, int idx);
        return base + idx * stagger;
    endfunction

endpackage

// File: rtl/sim_seq_sat_cnt.sv
// Saturating up-counter. Clear restarts the count; if enable is also high the
// clearing cycle itself is counted, so the next value is 1 instead of 0.
module sim_seq_sat_cnt
    import sim_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= en ? WIDTH'(1) : '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sim_seq_ctrl.sv
// Simulation sequencer: staggered per-domain reset release, saturating cycle
// count, progress pulses and finish handling (request/timeout/idle) with drain.
module sim_seq_ctrl
    import sim_seq_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 32,
    parameter int FREQ_W      = 16,
    parameter int RST_BASE    = 5,
    parameter int RST_STAGGER = 2,
    parameter int DRAIN       = 16
) (
    input  logic                sim_seq_clk_ip,
    input  logic                sim_seq_rst_n_ip,
    input  logic [CNT_W-1:0]    sim_seq_timeout_ip,
    input  logic [CNT_W-1:0]    sim_seq_idle_lim_ip,
    input  logic [FREQ_W-1:0]   sim_seq_freq_ip,
    input  logic [CHANNELS-1:0] sim_seq_kick_ip,
    input  logic                sim_seq_finish_req_ip,
    output logic [CHANNELS-1:0] sim_seq_rst_n_op,
    output logic [CNT_W-1:0]    sim_seq_cycles_op,
    output logic                sim_seq_report_op,
    output logic [1:0]          sim_seq_state_op,
    output logic [1:0]          sim_seq_reason_op,
    output logic                sim_seq_done_op
);

    localparam int DRAIN_W = $clog2(DRAIN) + 1;

    if (DRAIN < 1) begin : g_bad_drain
        $error("sim_seq_ctrl: DRAIN must be at least 1");
    end
    if ((CHANNELS < 1) || (CHANNELS > 16)) begin : g_bad_channels
        $error("sim_seq_ctrl: CHANNELS must be in 1..16");
    end
    if (RST_BASE < 1) begin : g_bad_base
        $error("sim_seq_ctrl: RST_BASE must be at least 1");
    end

    sim_seq_state_t  state_q, state_d;
    sim_seq_reason_t reason_q, reason_d;

    logic [CNT_W-1:0]    cycles, cycles_plus, idle_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [FREQ_W-1:0]   period_cnt, period_pos, freq_q;
    logic [CHANNELS-1:0] rst_n_q, release_now;
    logic cyc_inc, any_kick, ev_req, ev_timeout, ev_idle, last_release;
    logic period_chg, period_wrap, period_clr, period_en;
    logic report_q, done_q;

    // The cycle count stops in DONE and at saturation; everything keyed to
    // "the edge at which cycles becomes X" uses this increment qualifier.
    assign cyc_inc     = (state_q != ST_DONE) && (cycles != '1);
    assign cycles_plus = cycles + CNT_W'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_release
        assign release_now[i] = cyc_inc &&
            (cycles_plus == CNT_W'(rst_threshold(RST_BASE, RST_STAGGER, i)));
    end
    assign last_release = release_now[CHANNELS-1];

    assign any_kick   = |sim_seq_kick_ip;
    assign ev_req     = sim_seq_finish_req_ip;
    assign ev_timeout = (sim_seq_timeout_ip != '0) && (cycles >= sim_seq_timeout_ip);
    assign ev_idle    = (state_q == ST_RUN) && (sim_seq_idle_lim_ip != '0) &&
                        (idle_cnt >= sim_seq_idle_lim_ip) && !any_kick;

    sim_seq_sat_cnt #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (sim_seq_clk_ip),
        .rst_n (sim_seq_rst_n_ip),
        .clr   (1'b0),
        .en    (cyc_inc),
        .count (cycles)
    );

    sim_seq_sat_cnt #(.WIDTH(CNT_W)) u_idle_cnt (
        .clk   (sim_seq_clk_ip),
        .rst_n (sim_seq_rst_n_ip),
        .clr   (any_kick || (state_q != ST_RUN)),
        .en    ((state_q == ST_RUN) && !any_kick),
        .count (idle_cnt)
    );

    sim_seq_sat_cnt #(.WIDTH(DRAIN_W)) u_drain_cnt (
        .clk   (sim_seq_clk_ip),
        .rst_n (sim_seq_rst_n_ip),
        .clr   (state_q != ST_DRAIN),
        .en    (state_q == ST_DRAIN),
        .count (drain_cnt)
    );

    // A freq change makes the current cycle position 0 of a fresh period.
    assign period_chg  = (sim_seq_freq_ip != freq_q);
    assign period_pos  = period_chg ? '0 : period_cnt;
    assign period_wrap = cyc_inc && (sim_seq_freq_ip != '0) &&
                         (period_pos == (sim_seq_freq_ip - FREQ_W'(1)));
    assign period_clr  = (sim_seq_freq_ip == '0) || (cyc_inc && (period_wrap || period_chg));
    assign period_en   = cyc_inc && (sim_seq_freq_ip != '0) && !period_wrap;

    sim_seq_sat_cnt #(.WIDTH(FREQ_W)) u_period_cnt (
        .clk   (sim_seq_clk_ip),
        .rst_n (sim_seq_rst_n_ip),
        .clr   (period_clr),
        .en    (period_en),
        .count (period_cnt)
    );

    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        case (state_q)
            ST_RESET, ST_RUN: begin
                if (ev_req) begin
                    state_d  = ST_DRAIN;
                    reason_d = RSN_REQUEST;
                end else if (ev_timeout) begin
                    state_d  = ST_DRAIN;
                    reason_d = RSN_TIMEOUT;
                end else if (ev_idle) begin
                    state_d  = ST_DRAIN;
                    reason_d = RSN_IDLE;
                end else if ((state_q == ST_RESET) && last_release) begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_W'(DRAIN - 1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge sim_seq_clk_ip or negedge sim_seq_rst_n_ip) begin
        if (!sim_seq_rst_n_ip) begin
            state_q  <= ST_RESET;
            reason_q <= RSN_NONE;
            rst_n_q  <= '0;
            report_q <= 1'b0;
            done_q   <= 1'b0;
            freq_q   <= '0;
        end else begin
            state_q  <= state_d;
            reason_q <= reason_d;
            rst_n_q  <= rst_n_q | release_now;
            report_q <= period_wrap && (state_d != ST_DONE);
            done_q   <= (state_d == ST_DONE);
            freq_q   <= sim_seq_freq_ip;
        end
    end

    assign sim_seq_rst_n_op  = rst_n_q;
    assign sim_seq_cycles_op = cycles;
    assign sim_seq_report_op = report_q;
    assign sim_seq_state_op  = state_q;
    assign sim_seq_reason_op = reason_q;
    assign sim_seq_done_op   = done_q;

endmodule
